gate_checker: RTL and testbench
===============================

# gate_checker

Synthesizable response checker for small combinational gates: it is the consuming end of the exhaustive-stimulus flow used for the lab gates. It walks every input pattern and drives the pattern onto the DUT inputs. After a fixed settle time it samples the DUT output, compares it against a parameterised truth table, and reports an error count, the first failing pattern, and pass/fail. It sits beside the gate under test: its pattern output feeds the gate inputs and the gate output returns to it.

## Interface
- N, 2: number of DUT inputs; legal range 1..6.
- TRUTH, 4'b1000: expected output per pattern, 2**N bits. Bit i is the expected output for input pattern i; the default is a 2-input AND.
- SETTLE, 2: cycles each pattern is held before sampling; must be >= 1.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- start  in  1  begin a check run; sampled in IDLE or DONE only
- dut_in  out  N  pattern driven to the DUT; bit N-1 is the MSB, i.e. the first gate input
- dut_out  in  1  DUT response
- busy  out  1  run in progress
- done  out  1  run complete; held until the next start
- pass  out  1  valid when done; 1 if err_count == 0
- err_count  out  N+1  number of mismatching patterns, 0..2**N
- first_fail  out  N  lowest failing pattern; valid when fail_valid
- fail_valid  out  1  at least one mismatch seen this run

## Operation
- Registered FSM with states IDLE, DRIVE, SAMPLE and DONE. A settle counter, width clog2(SETTLE+1), runs in DRIVE.
- IDLE: busy=0, done=0. When start=1, go to DRIVE and in the same edge:
  - set dut_in=0 and settle counter=0;
  - clear err_count, fail_valid and first_fail.
- DRIVE: busy=1. The counter increments each cycle. When counter==SETTLE-1, go to SAMPLE. DRIVE therefore lasts exactly SETTLE cycles.
- SAMPLE: compare dut_out with TRUTH[dut_in]. On a mismatch:
  - increment err_count;
  - if fail_valid=0, set first_fail=dut_in and fail_valid=1.
- SAMPLE next state:
  - if dut_in == 2**N-1, go to DONE;
  - otherwise increment dut_in, clear the counter and go to DRIVE.
- DONE: busy=0, done=1, pass=(err_count==0).
  - dut_in returns to 0.
  - err_count, first_fail and fail_valid hold.
  - start=1 restarts exactly as from IDLE; done drops on that edge.
- start while busy is ignored.
- dut_out is only looked at in SAMPLE; values in DRIVE cycles have no effect.
- In simulation, X or Z on dut_out in SAMPLE counts as a mismatch: use case-inequality semantics behind a simulation-only guard.
- err_count never wraps, because its maximum of 2**N fits in N+1 bits.

## Timing
- Reset value of every output is 0: dut_in, busy, done, pass, err_count, first_fail, fail_valid. State returns to IDLE.
- Reset asserted mid-run aborts immediately, asynchronously. No partial results are kept.
- Each pattern occupies SETTLE+1 cycles: SETTLE in DRIVE, 1 in SAMPLE.
- From the clock edge that accepts start to the edge at which done rises: 2**N*(SETTLE+1) cycles. For the defaults this is 12.
- dut_in changes only on the edge leaving SAMPLE and on the start edge. It is stable for the full SETTLE+1 cycles of its pattern.
- busy rises on the start edge and falls on the same edge that done rises.
- err_count and fail_valid update on the edge that ends SAMPLE. They are visible one cycle later than the sampled dut_out.

## Test plan
- Correct AND model, defaults, pulse start: done after exactly 12 cycles, with:
  - dut_in sequence 0,1,2,3, each held 3 cycles;
  - err_count=0, pass=1, fail_valid=0.
- DUT stuck-at-1, defaults: err_count=3, first_fail=2'b00, fail_valid=1, pass=0.
- OR-gate model checked against the AND truth table: err_count=2 (patterns 1 and 2), first_fail=2'b01, pass=0.
- Settle check: model whose output is wrong during the first SETTLE-1 cycles of each pattern and correct in the last DRIVE cycle and in SAMPLE. Required response: err_count=0, pass=1. The same model with SETTLE=1 is still clean.
- Reset mid-run: deassert rst_n 5 cycles after start; all outputs are 0 immediately. Release reset, issue start; the full 12-cycle run completes with correct results and no residue from the aborted run.
- Control stress: start pulsed while busy causes no restart and completion stays at cycle 12. start held high continuously gives done=1 for exactly one cycle, then a new run with counters cleared. Repeat with N=3, TRUTH=8'h96 against a 3-input XOR model: 32 cycles, pass=1.

Source files
------------

// File: rtl/gate_checker.sv
// Exhaustive response checker for small combinational gates: walks every input
// pattern, waits SETTLE cycles, samples the gate output and scores it against TRUTH.
module gate_checker #(
    parameter int                  N      = 2,
    parameter logic [(1<<N)-1:0]   TRUTH  = 4'b1000,
    parameter int                  SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] dut_in,
    input  logic         dut_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic [N-1:0] first_fail,
    output logic         fail_valid
);

    localparam int                CW          = $clog2(SETTLE + 1);
    localparam int                EW          = N + 1;
    localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [N:0]        MAX_ERR     = EW'(1 << N);
    localparam logic [(1<<N)-1:0] TT          = TRUTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  dut_in_q, dut_in_d;
    logic [N:0]    err_q, err_d;
    logic [N-1:0]  ff_q, ff_d;
    logic          fv_q, fv_d;
    logic          expected_bit;
    logic          mismatch;

    assign expected_bit = TT[dut_in_q];

    // X/Z on the gate output must score as a failure in simulation.
`ifdef SYNTHESIS
    assign mismatch = (dut_out != expected_bit);
`else
    assign mismatch = (dut_out !== expected_bit);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dut_in_d = dut_in_q;
        err_d    = err_q;
        ff_d     = ff_q;
        fv_d     = fv_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    dut_in_d = '0;
                    cnt_d    = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    fv_d     = 1'b0;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!fv_q) begin
                        ff_d = dut_in_q;
                        fv_d = 1'b1;
                    end
                end
                if (&dut_in_q) begin
                    state_d  = DONE;
                    dut_in_d = '0;
                end else begin
                    state_d  = DRIVE;
                    dut_in_d = dut_in_q + 1'b1;
                    cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dut_in_q <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dut_in_q <= dut_in_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
            fv_q     <= fv_d;
        end
    end

    assign dut_in     = dut_in_q;
    assign busy       = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
    assert property (@(posedge clk) disable iff (!rst_n) err_q <= MAX_ERR);
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker: three checker instances with behavioural gate
// models; expected run results are queued at stimulus time and popped on done.
`timescale 1ns/1ps
module tb_gate_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, start1, start2;
    logic [1:0] din0, din1;
    logic [2:0] din2;
    logic dout0, dout1, dout2;
    logic busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [2:0] ec0, ec1;
    logic [3:0] ec2;
    logic [1:0] ff0, ff1;
    logic [2:0] ff2;
    logic fv0, fv1, fv2;

    gate_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_in(din0), .dut_out(dout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0),
        .first_fail(ff0), .fail_valid(fv0)
    );
    gate_checker #(.N(2), .TRUTH(4'b1000), .SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(din1), .dut_out(dout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1),
        .first_fail(ff1), .fail_valid(fv1)
    );
    gate_checker #(.N(3), .TRUTH(8'h96), .SETTLE(3)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(din2), .dut_out(dout2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2),
        .first_fail(ff2), .fail_valid(fv2)
    );

    logic [2:0] din_a [3];
    logic [3:0] ec_a [3];
    logic [2:0] ff_a [3];
    logic busy_a [3];
    logic done_a [3];
    logic pass_a [3];
    logic fv_a [3];
    assign din_a[0] = {1'b0, din0};
    assign din_a[1] = {1'b0, din1};
    assign din_a[2] = din2;
    assign ec_a[0] = {1'b0, ec0};
    assign ec_a[1] = {1'b0, ec1};
    assign ec_a[2] = ec2;
    assign ff_a[0] = {1'b0, ff0};
    assign ff_a[1] = {1'b0, ff1};
    assign ff_a[2] = ff2;
    assign busy_a[0] = busy0;
    assign busy_a[1] = busy1;
    assign busy_a[2] = busy2;
    assign done_a[0] = done0;
    assign done_a[1] = done1;
    assign done_a[2] = done2;
    assign pass_a[0] = pass0;
    assign pass_a[1] = pass1;
    assign pass_a[2] = pass2;
    assign fv_a[0] = fv0;
    assign fv_a[1] = fv1;
    assign fv_a[2] = fv2;

    function automatic int n_of(int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic int settle_of(int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    // Gate models: 0 correct, 1 stuck-at-1, 2 OR, 3 slow-settling, 4 stuck-at-0, 5 inverted
    int mode [3];
    int age [3];
    logic [2:0] last_in [3];
    logic busy_last [3];

    function automatic logic model(int m, int k, logic [2:0] d, int a);
        logic good;
        good = (k == 2) ? ^d : (d[1] & d[0]);
        case (m)
            1: return 1'b1;
            2: return d[1] | d[0];
            3: return good ^ (a < settle_of(k) - 1);
            4: return 1'b0;
            5: return ~good;
            default: return good;
        endcase
    endfunction

    always_comb dout0 = model(mode[0], 0, din_a[0], age[0]);
    always_comb dout1 = model(mode[1], 1, din_a[1], age[1]);
    always_comb dout2 = model(mode[2], 2, din_a[2], age[2]);

    // Cycles since the current pattern was first presented.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!busy_last[k] || din_a[k] != last_in[k]) age[k] <= 0;
            else age[k] <= age[k] + 1;
            last_in[k]   <= din_a[k];
            busy_last[k] <= busy_a[k];
        end
    end

    typedef struct {
        int inst;
        int ec;
        int ff;
        int fv;
        int ps;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(string name, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    int cyc [3];
    logic done_prev [3];
    logic busy_prev [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 0;
            done_prev[k] = 1'b0;
            busy_prev[k] = 1'b0;
            mode[k] = 0;
        end
    end

    // Monitor: pattern sequencing while busy, result scoring on each done rise.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (busy_a[k]) begin
                cyc[k] = busy_prev[k] ? cyc[k] + 1 : 1;
                check($sformatf("u%0d_dut_in_cyc%0d", k, cyc[k]), int'(din_a[k]),
                      (cyc[k] - 1) / (settle_of(k) + 1));
            end
            if (done_a[k] && !done_prev[k]) begin
                if (exp_q.size() == 0 || exp_q[0].inst != k) begin
                    check($sformatf("u%0d_unexpected_done", k), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] u%0d run done: err_count=%0d first_fail=%0d fail_valid=%0d pass=%0d cycles=%0d",
                             k, ec_a[k], ff_a[k], fv_a[k], pass_a[k], cyc[k]);
                    check($sformatf("u%0d_err_count", k), int'(ec_a[k]), e.ec);
                    check($sformatf("u%0d_first_fail", k), int'(ff_a[k]), e.ff);
                    check($sformatf("u%0d_fail_valid", k), int'(fv_a[k]), e.fv);
                    check($sformatf("u%0d_pass", k), int'(pass_a[k]), e.ps);
                    check($sformatf("u%0d_run_cycles", k), cyc[k], e.cyc);
                    check($sformatf("u%0d_busy_at_done", k), int'(busy_a[k]), 0);
                    check($sformatf("u%0d_dut_in_at_done", k), int'(din_a[k]), 0);
                end
            end
            done_prev[k] = done_a[k];
            busy_prev[k] = busy_a[k];
        end
    end

    task automatic set_start(int k, logic v);
        case (k)
            0: start0 = v;
            1: start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic expect_run(int k, int e_ec, int e_ff, int e_fv);
        exp_t e;
        e.inst = k;
        e.ec   = e_ec;
        e.ff   = e_ff;
        e.fv   = e_fv;
        e.ps   = (e_ec == 0) ? 1 : 0;
        e.cyc  = (1 << n_of(k)) * (settle_of(k) + 1);
        exp_q.push_back(e);
    endtask

    task automatic wait_done(int k, int bound);
        int i;
        i = 0;
        while (!done_a[k] && i < bound) begin
            @(negedge clk);
            i++;
        end
        if (!done_a[k]) begin
            tests++;
            fails++;
            $display("FAIL u%0d_done_timeout: got done=0 after %0d cycles, expected done=1", k, bound);
        end
    endtask

    task automatic run(int k, int m, int e_ec, int e_ff, int e_fv);
        expect_run(k, e_ec, e_ff, e_fv);
        @(negedge clk);
        mode[k] = m;
        set_start(k, 1'b1);
        @(negedge clk);
        set_start(k, 1'b0);
        wait_done(k, 60);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_dut_in"}, int'(din0), 0);
        check({tag, "_busy"}, int'(busy0), 0);
        check({tag, "_done"}, int'(done0), 0);
        check({tag, "_pass"}, int'(pass0), 0);
        check({tag, "_err_count"}, int'(ec0), 0);
        check({tag, "_first_fail"}, int'(ff0), 0);
        check({tag, "_fail_valid"}, int'(fv0), 0);
    endtask

    initial begin
        rst_n  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("reset_u2_busy", int'(busy2), 0);
        check("reset_u2_err_count", int'(ec2), 0);
        rst_n = 1'b1;

        run(0, 0, 0, 0, 0);   // correct AND
        run(0, 1, 3, 0, 1);   // stuck-at-1: patterns 0,1,2 fail
        run(0, 2, 2, 1, 1);   // OR against AND: patterns 1,2 fail
        run(0, 3, 0, 0, 0);   // slow settling, SETTLE=2
        run(1, 3, 0, 0, 0);   // same model, SETTLE=1
        run(1, 4, 1, 3, 1);   // stuck-at-0: only last pattern fails

        // Abort mid-run with errors already accumulated
        @(negedge clk);
        mode[0] = 1;
        start0  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_abort_busy", int'(busy0), 1);
        check("pre_abort_err_count", int'(ec0), 1);
        check("pre_abort_dut_in", int'(din0), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 0, 0, 0, 0);

        // start pulsed while busy must be ignored
        expect_run(0, 0, 0, 0);
        @(negedge clk);
        mode[0] = 0;
        start0  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 60);

        // start held high: done lasts one cycle, then a fresh run
        expect_run(0, 3, 0, 1);
        expect_run(0, 3, 0, 1);
        @(negedge clk);
        mode[0] = 1;
        start0  = 1'b1;
        @(negedge clk);
        wait_done(0, 60);
        @(negedge clk);
        check("held_done_one_cycle", int'(done0), 0);
        check("held_restart_busy", int'(busy0), 1);
        check("held_restart_err_cleared", int'(ec0), 0);
        check("held_restart_fv_cleared", int'(fv0), 0);
        start0 = 1'b0;
        wait_done(0, 60);

        run(2, 0, 0, 0, 0);   // 3-input XOR, 32 cycles
        run(2, 3, 0, 0, 0);   // slow settling, SETTLE=3
        run(2, 5, 8, 0, 1);   // every pattern wrong: err_count hits 2**N
        run(2, 4, 4, 1, 1);   // stuck-at-0: patterns 1,2,4,7 fail

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
